fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Forwarding and load-use interlock controller for the 5-stage MIPS pipeline. It tracks the destination tags of the in-flight instructions in EX, MEM and WB. It also drives the 2-bit operand selects of the two EX-stage 3:1 operand multiplexers (0 = register file, 1 = EX/MEM result, 2 = MEM/WB result), and stalls IF/ID when a value cannot be forwarded in time.

## Interface
Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  a real instruction occupies ID
- id_rs  in  REG_W  first source register of the ID instruction
- id_rt  in  REG_W  second source register of the ID instruction
- id_wreg  in  1  ID instruction writes the register file
- id_wdst  in  REG_W  destination register of the ID instruction
- id_mem_rd  in  1  ID instruction is a load
- flush  in  1  squash the ID instruction (branch taken)
- fwd_a  out  2  select for operand-A mux of the instruction in EX
- fwd_b  out  2  select for operand-B mux of the instruction in EX
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- stall_cnt  out  CNT_W  number of stall cycles since reset, saturating

## Operation
- Internal tag pipeline with three entries: EX, MEM, WB. Each entry holds {wreg, dst, mem_rd}. A bubble is all zeros.
- A producer matches source s when its wreg=1, its dst==s, and s!=0. Register $0 never matches.
- Hazard check (combinational, on ID):
  - EX entry is a load and matches id_rs or id_rt → load_use.
  - stall = id_valid & load_use & ~flush.
- Select computation for each source, evaluated against the entries that will sit in MEM and WB after the edge:
  - EX entry matches → 1.
  - Else MEM entry matches → 2.
  - Else → 0.
  - The newer producer wins: if both match, the result is 1.
- The register file is write-before-read, so a producer in WB is never a hazard for ID.
- Advance on every non-reset edge:
  - WB←MEM, MEM←EX.
  - EX←bubble if stall|flush|~id_valid; otherwise EX←{id_wreg, id_wdst, id_mem_rd}.
  - fwd_a/fwd_b←computed selects, or 0 when EX is loaded with a bubble.
- stall_cnt increments on each edge where stall=1 and holds at all-ones.
- flush has priority over stall: a flushed instruction never stalls.

## Timing
- Reset: all tag entries become bubbles, fwd_a=fwd_b=0, stall_cnt=0, and stall=0 on the first cycle after reset.
- fwd_a/fwd_b are registered. They are valid during the whole cycle the consuming instruction is in EX, one edge after it leaves ID.
- stall is combinational from the inputs and the EX entry, settled within the same cycle. Upstream samples it at the next edge.
- Load-use costs exactly one stall cycle:
  - Cycle n: stall=1 and a bubble enters EX.
  - Cycle n+1: the load is in MEM, the check passes, and the consumer receives select 2 at the next edge.
- rst asserted mid-stall wins: all entries are cleared and stall drops in the cycle after the reset edge.
- id_valid=0 yields stall=0 regardless of tags.

## Configuration
- FWD_HAZARD_FORWARD_EN defined: forwarding behaviour as above.
- Undefined: pure interlock.
  - fwd_a and fwd_b are tied to 0.
  - stall=1 whenever the EX or MEM entry matches id_rs or id_rt (regardless of mem_rd).
  - stall_cnt behaves identically in both modes.

## Structure
- Shared package pipe_pkg holds:
  - FWD_REG=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2.
  - The tag record typedef {wreg, dst, mem_rd}.
  - The BUBBLE constant.
- One sub-module, tag_match: a combinational compare of a tag against a source index, with the $0 exclusion. It is instantiated for EX×{rs,rt} and MEM×{rs,rt}.

## Test plan
- Reset, then idle with id_valid=0 → fwd_a=fwd_b=0, stall=0, stall_cnt=0.
- Issue add $3 followed by sub $4,$3,$5 back-to-back → when sub is in EX, fwd_a=1, fwd_b=0, and no stall.
- Issue add $3, then an unrelated instruction, then or $6,$7,$3 → fwd_b=2 for the or. With add $3 twice in sequence before the consumer, fwd=1 (newer producer wins).
- Issue lw $8 followed by add $9,$8,$8 → exactly one cycle of stall=1, stall_cnt=1, and then fwd_a=fwd_b=2.
- Issue lw $0 followed by a consumer of $0, and separately a flush asserted together with a load-use → stall=0 and select 0 in both cases; for the flushed case EX receives a bubble.
- Build without FWD_HAZARD_FORWARD_EN and issue add $3 followed by sub $4,$3,$5 → stall for 2 cycles, fwd always 0, stall_cnt=2. Assert rst during the stall → stall=0 the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand-select codes, the in-flight tag record
// and the bubble constant used by the forwarding/interlock logic.
package pipe_pkg;

  // Width of the destination field carried in each tag entry.
  localparam int TAG_DST_W = 5;

  // Operand mux select codes for the EX-stage 3:1 multiplexers.
  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // Per-stage record of what an in-flight instruction will write.
  typedef struct packed {
    logic                 wreg;
    logic [TAG_DST_W-1:0] dst;
    logic                 mem_rd;
  } tag_t;

  // An empty slot: writes nothing, so it never matches a source.
  localparam tag_t BUBBLE = '0;

endpackage

// File: rtl/tag_match.sv
// Combinational producer/consumer compare: a tag matches a source register
// when it writes the register file, its destination equals the source, and
// the source is not $0 (hard-wired zero never needs forwarding).
module tag_match
  import pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  tag_t             tag,
  input  logic [REG_W-1:0] src,
  output logic             hit
);

  // The load flag is irrelevant to a plain match; the caller qualifies it.
  logic unused_mem_rd;
  assign unused_mem_rd = tag.mem_rd;

  // Match only real writers of a non-zero register.
  assign hit = tag.wreg && (tag.dst == TAG_DST_W'(src)) && (src != '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use interlock controller for the 5-stage pipeline.
// Tracks EX/MEM/WB destination tags, registers the EX operand selects and
// raises a combinational stall for IF/ID.
// Build option FWD_HAZARD_FORWARD_EN: when defined, operands are forwarded
// and only load-use stalls; when undefined, the unit is a pure interlock that
// stalls on any EX or MEM producer and keeps both selects at zero.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_wreg,
  input  logic [REG_W-1:0] id_wdst,
  input  logic             id_mem_rd,
  input  logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  // Hit vector index: {producer, source}; producer 0 = EX, 1 = MEM,
  // source 0 = rs, 1 = rt.
  localparam int H_EX_RS  = 0;
  localparam int H_EX_RT  = 1;
  localparam int H_MEM_RS = 2;
  localparam int H_MEM_RT = 3;

  tag_t             ex_reg, mem_reg, wb_reg;
  tag_t             ex_next;
  logic [1:0]       fwd_a_reg, fwd_b_reg;
  logic [1:0]       sel_a_next, sel_b_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             hazard;
  logic             ex_bubble;
  logic [3:0]       hit_vec;

  tag_t             prod [2];
  logic [REG_W-1:0] srcs [2];

  assign prod[0] = ex_reg;
  assign prod[1] = mem_reg;
  assign srcs[0] = id_rs;
  assign srcs[1] = id_rt;

  // One comparator per (producer, source) pair: EX x {rs,rt}, MEM x {rs,rt}.
  for (genvar gi = 0; gi < 2; gi++) begin : g_prod
    for (genvar gj = 0; gj < 2; gj++) begin : g_src
      tag_match #(.REG_W(REG_W)) u_match (
        .tag (prod[gi]),
        .src (srcs[gj]),
        .hit (hit_vec[gi*2 + gj])
      );
    end
  end

  // The WB tag is kept for pipeline visibility only: the register file is
  // write-before-read, so a WB producer is never a hazard for ID.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{wb_reg, mem_reg.mem_rd, ex_reg.mem_rd};

  // Hazard detection and next operand selects for the instruction in ID.
  always_comb begin
    hazard     = 1'b0;
    sel_a_next = FWD_REG;
    sel_b_next = FWD_REG;
`ifdef FWD_HAZARD_FORWARD_EN
    // Only a load in EX is too late to forward; the newer EX producer wins.
    hazard = ex_reg.mem_rd & (hit_vec[H_EX_RS] | hit_vec[H_EX_RT]);
    if (hit_vec[H_EX_RS])       sel_a_next = FWD_EXMEM;
    else if (hit_vec[H_MEM_RS]) sel_a_next = FWD_MEMWB;
    if (hit_vec[H_EX_RT])       sel_b_next = FWD_EXMEM;
    else if (hit_vec[H_MEM_RT]) sel_b_next = FWD_MEMWB;
`else
    // Without forwarding, any producer still in EX or MEM must drain first.
    hazard = |hit_vec;
`endif
  end

  // Flush dominates: a squashed instruction never stalls.
  assign stall     = id_valid & hazard & ~flush;
  assign ex_bubble = stall | flush | ~id_valid;

  // Tag entering EX: the ID instruction, or a bubble when it cannot advance.
  always_comb begin
    ex_next = BUBBLE;
    if (!ex_bubble) begin
      ex_next.wreg   = id_wreg;
      ex_next.dst    = TAG_DST_W'(id_wdst);
      ex_next.mem_rd = id_mem_rd;
    end
  end

  // Advance the tag pipeline, register the selects and count stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg        <= BUBBLE;
      mem_reg       <= BUBBLE;
      wb_reg        <= BUBBLE;
      fwd_a_reg     <= FWD_REG;
      fwd_b_reg     <= FWD_REG;
      stall_cnt_reg <= '0;
    end else begin
      wb_reg    <= mem_reg;
      mem_reg   <= ex_reg;
      ex_reg    <= ex_next;
      fwd_a_reg <= ex_bubble ? FWD_REG : sel_a_next;
      fwd_b_reg <= ex_bubble ? FWD_REG : sel_b_next;
      if (stall && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  assign fwd_a     = fwd_a_reg;
  assign fwd_b     = fwd_b_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit. Expected stall values are checked in the
// issue cycle; expected operand selects are queued at issue and checked after
// the edge that moves the instruction into EX. Expectations follow the build
// mode selected by FWD_HAZARD_FORWARD_EN.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_wreg;
  logic [4:0]  id_wdst;
  logic        id_mem_rd;
  logic        flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        stall;
  logic [15:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  fwd_hazard_unit #(.REG_W(5), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_wreg   (id_wreg),
    .id_wdst   (id_wdst),
    .id_mem_rd (id_mem_rd),
    .flush     (flush),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one ID-stage cycle at the falling edge, check stall in-cycle,
  // queue the expected selects and check them after the next rising edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic w, input logic [4:0] d, input logic m,
                      input logic fl, input logic exp_stall,
                      input logic [1:0] ea, input logic [1:0] eb);
    exp_t e;
    rst = r; id_valid = v; id_rs = rs; id_rt = rt;
    id_wreg = w; id_wdst = d; id_mem_rd = m; flush = fl;
    #1;
    check({tag, " stall"}, {31'd0, stall}, {31'd0, exp_stall});
    e.a = ea; e.b = eb; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, " fwd_a"}, {30'd0, fwd_a}, {30'd0, e.a});
      check({e.tag, " fwd_b"}, {30'd0, fwd_b}, {30'd0, e.b});
    end
    $display("step %s: stall=%0b fwd_a=%0d fwd_b=%0d stall_cnt=%0d", tag, stall, fwd_a, fwd_b, stall_cnt);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0;
    id_wreg = 1'b0; id_wdst = '0; id_mem_rd = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset fwd_a", {30'd0, fwd_a}, 32'd0);
    check("reset fwd_b", {30'd0, fwd_b}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk);

    //    tag           rst   vld   rs  rt  w     dst m     fl    stall a  b
`ifdef FWD_HAZARD_FORWARD_EN
    step("idle",        1'b0, 1'b0, 0,  0,  1'b0, 0,  1'b0, 1'b0, 1'b0, 0, 0);
    step("add3",        1'b0, 1'b1, 1,  2,  1'b1, 3,  1'b0, 1'b0, 1'b0, 0, 0);
    step("sub_ex",      1'b0, 1'b1, 3,  5,  1'b1, 4,  1'b0, 1'b0, 1'b0, 1, 0);
    step("add3_b",      1'b0, 1'b1, 1,  2,  1'b1, 3,  1'b0, 1'b0, 1'b0, 0, 0);
    step("unrel",       1'b0, 1'b1, 10, 11, 1'b1, 12, 1'b0, 1'b0, 1'b0, 0, 0);
    step("or_mem",      1'b0, 1'b1, 7,  3,  1'b1, 6,  1'b0, 1'b0, 1'b0, 0, 2);
    step("add3_c",      1'b0, 1'b1, 1,  2,  1'b1, 3,  1'b0, 1'b0, 1'b0, 0, 0);
    step("add3_d",      1'b0, 1'b1, 1,  2,  1'b1, 3,  1'b0, 1'b0, 1'b0, 0, 0);
    step("newer_wins",  1'b0, 1'b1, 3,  3,  1'b1, 13, 1'b0, 1'b0, 1'b0, 1, 1);
    step("lw8",         1'b0, 1'b1, 1,  0,  1'b1, 8,  1'b1, 1'b0, 1'b0, 0, 0);
    step("lu_stall",    1'b0, 1'b1, 8,  8,  1'b1, 9,  1'b0, 1'b0, 1'b1, 0, 0);
    check("lu stall_cnt", {16'd0, stall_cnt}, 32'd1);
    step("lu_fwd",      1'b0, 1'b1, 8,  8,  1'b1, 9,  1'b0, 1'b0, 1'b0, 2, 2);
    check("lu stall_cnt hold", {16'd0, stall_cnt}, 32'd1);
    step("lw0",         1'b0, 1'b1, 1,  2,  1'b1, 0,  1'b1, 1'b0, 1'b0, 0, 0);
    step("use0",        1'b0, 1'b1, 0,  0,  1'b1, 7,  1'b0, 1'b0, 1'b0, 0, 0);
    step("lw8_f",       1'b0, 1'b1, 1,  2,  1'b1, 8,  1'b1, 1'b0, 1'b0, 0, 0);
    step("flush_lu",    1'b0, 1'b1, 8,  8,  1'b1, 9,  1'b0, 1'b1, 1'b0, 0, 0);
    step("after_flush", 1'b0, 1'b1, 9,  9,  1'b1, 10, 1'b0, 1'b0, 1'b0, 0, 0);
    step("lw8_v",       1'b0, 1'b1, 1,  2,  1'b1, 8,  1'b1, 1'b0, 1'b0, 0, 0);
    step("invalid_use", 1'b0, 1'b0, 8,  8,  1'b1, 9,  1'b0, 1'b0, 1'b0, 0, 0);
    check("flush stall_cnt", {16'd0, stall_cnt}, 32'd1);
    step("lw8_r",       1'b0, 1'b1, 1,  2,  1'b1, 8,  1'b1, 1'b0, 1'b0, 0, 0);
    step("rst_in_stall",1'b1, 1'b1, 8,  8,  1'b1, 9,  1'b0, 1'b0, 1'b1, 0, 0);
    step("after_rst",   1'b0, 1'b1, 8,  8,  1'b1, 9,  1'b0, 1'b0, 1'b0, 0, 0);
    check("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
`else
    step("idle",        1'b0, 1'b0, 0,  0,  1'b0, 0,  1'b0, 1'b0, 1'b0, 0, 0);
    step("add3",        1'b0, 1'b1, 1,  2,  1'b1, 3,  1'b0, 1'b0, 1'b0, 0, 0);
    step("sub_st1",     1'b0, 1'b1, 3,  5,  1'b1, 4,  1'b0, 1'b0, 1'b1, 0, 0);
    step("sub_st2",     1'b0, 1'b1, 3,  5,  1'b1, 4,  1'b0, 1'b0, 1'b1, 0, 0);
    step("sub_go",      1'b0, 1'b1, 3,  5,  1'b1, 4,  1'b0, 1'b0, 1'b0, 0, 0);
    check("interlock stall_cnt", {16'd0, stall_cnt}, 32'd2);
    step("add0",        1'b0, 1'b1, 1,  2,  1'b1, 0,  1'b0, 1'b0, 1'b0, 0, 0);
    step("use0",        1'b0, 1'b1, 0,  0,  1'b1, 7,  1'b0, 1'b0, 1'b0, 0, 0);
    step("add3_v",      1'b0, 1'b1, 1,  2,  1'b1, 3,  1'b0, 1'b0, 1'b0, 0, 0);
    step("invalid_use", 1'b0, 1'b0, 3,  3,  1'b1, 9,  1'b0, 1'b0, 1'b0, 0, 0);
    step("idle2",       1'b0, 1'b0, 0,  0,  1'b0, 0,  1'b0, 1'b0, 1'b0, 0, 0);
    step("add3_f",      1'b0, 1'b1, 1,  2,  1'b1, 3,  1'b0, 1'b0, 1'b0, 0, 0);
    step("flush_use",   1'b0, 1'b1, 3,  5,  1'b1, 4,  1'b0, 1'b1, 1'b0, 0, 0);
    step("after_flush", 1'b0, 1'b1, 4,  4,  1'b1, 6,  1'b0, 1'b0, 1'b0, 0, 0);
    check("flush stall_cnt", {16'd0, stall_cnt}, 32'd2);
    step("lw8",         1'b0, 1'b1, 1,  0,  1'b1, 8,  1'b1, 1'b0, 1'b0, 0, 0);
    step("lu_st1",      1'b0, 1'b1, 8,  8,  1'b1, 9,  1'b0, 1'b0, 1'b1, 0, 0);
    step("lu_st2",      1'b0, 1'b1, 8,  8,  1'b1, 9,  1'b0, 1'b0, 1'b1, 0, 0);
    step("lu_go",       1'b0, 1'b1, 8,  8,  1'b1, 9,  1'b0, 1'b0, 1'b0, 0, 0);
    check("load stall_cnt", {16'd0, stall_cnt}, 32'd4);
    step("add3_r",      1'b0, 1'b1, 1,  2,  1'b1, 3,  1'b0, 1'b0, 1'b0, 0, 0);
    step("rst_in_stall",1'b1, 1'b1, 3,  5,  1'b1, 4,  1'b0, 1'b0, 1'b1, 0, 0);
    step("after_rst",   1'b0, 1'b1, 3,  5,  1'b1, 4,  1'b0, 1'b0, 1'b0, 0, 0);
    check("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    step("idle_end",    1'b0, 1'b0, 0,  0,  1'b0, 0,  1'b0, 1'b0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
